// File: rtl/uart_xcvr.sv
// uart_xcvr: one-word memory-mapped 8N1 UART. Writes queue a byte on uart_tx;
// reads return {frame_err, overrun, tx_busy, rx_valid, rx_data} and clear the flags.
module uart_xcvr #(
    parameter int CLKS_PER_BIT = 216
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        uart_valid,
    input  logic        uart_instr,
    input  logic [31:0] uart_addr,
    input  logic [31:0] uart_wdata,
    input  logic [3:0]  uart_wstrb,
    output logic [31:0] uart_rdata,
    output logic        uart_ready,
    input  logic        uart_rx,
    output logic        uart_tx
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_MAX = CNT_W'((CLKS_PER_BIT + 1) / 2 - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

    logic unused_ok;
    assign unused_ok = ^{uart_instr, uart_addr, uart_wdata[31:8]};

    logic       req_pending, req_write, req_byte;
    logic [7:0] req_data;

    uart_state_t      tx_state, tx_next;
    logic [CNT_W-1:0] tx_cnt;
    logic [2:0]       tx_bit;
    logic [7:0]       tx_shift;
    logic             tx_bit_end, tx_load, tx_busy;

    uart_state_t      rx_state, rx_next;
    logic [CNT_W-1:0] rx_cnt;
    logic [2:0]       rx_bit;
    logic [7:0]       rx_shift, rx_data;
    logic             rx_meta, rx_sync, rx_prev, rx_sample;
    logic             rx_valid, overrun, frame_err, rx_done_ok, rx_done_bad;
    logic             rd_clear;

    // A stalled byte write stays pending here until the TX FSM drains.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            req_pending <= 1'b0;
            req_write   <= 1'b0;
            req_byte    <= 1'b0;
            req_data    <= '0;
        end else if (uart_valid) begin
            req_pending <= 1'b1;
            req_write   <= |uart_wstrb;
            req_byte    <= uart_wstrb[0];
            req_data    <= uart_wdata[7:0];
        end else if (uart_ready) begin
            req_pending <= 1'b0;
        end
    end

    assign tx_busy    = (tx_state != IDLE);
    assign tx_load    = req_pending && req_byte && !tx_busy;
    assign uart_ready = req_pending && (!req_byte || !tx_busy);
    assign rd_clear   = uart_ready && !req_write;
    assign uart_rdata = rd_clear ? {20'b0, frame_err, overrun, tx_busy, rx_valid, rx_data} : 32'b0;

    assign tx_bit_end = (tx_cnt == CNT_MAX);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) tx_state <= IDLE;
        else        tx_state <= tx_next;
    end

    always_comb begin
        tx_next = tx_state;
        uart_tx = 1'b1;
        case (tx_state)
            IDLE:  if (tx_load) tx_next = START;
            START: begin
                uart_tx = 1'b0;
                if (tx_bit_end) tx_next = DATA;
            end
            DATA: begin
                uart_tx = tx_shift[0];
                if (tx_bit_end && tx_bit == 3'd7) tx_next = STOP;
            end
            STOP:  if (tx_bit_end) tx_next = IDLE;
            default: tx_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
        end else begin
            tx_cnt <= (!tx_busy || tx_bit_end) ? '0 : tx_cnt + CNT_W'(1);
            if (tx_load) begin
                tx_shift <= req_data;
            end else if (tx_state == DATA && tx_bit_end) begin
                tx_shift <= {1'b0, tx_shift[7:1]};
                tx_bit   <= tx_bit + 3'd1;
            end
        end
    end

    // rx_prev keeps one more synchronised sample so a falling edge can be seen.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= uart_rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    assign rx_sample   = (rx_state == START && rx_cnt == HALF_MAX) ||
                         ((rx_state == DATA || rx_state == STOP) && rx_cnt == CNT_MAX);
    assign rx_done_ok  = (rx_state == STOP) && rx_sample && rx_sync;
    assign rx_done_bad = (rx_state == STOP) && rx_sample && !rx_sync;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) rx_state <= IDLE;
        else        rx_state <= rx_next;
    end

    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            IDLE:  if (rx_prev && !rx_sync) rx_next = START;
            START: if (rx_sample) rx_next = rx_sync ? IDLE : DATA;
            DATA:  if (rx_sample && rx_bit == 3'd7) rx_next = STOP;
            STOP:  if (rx_sample) rx_next = IDLE;
            default: rx_next = IDLE;
        endcase
    end

    // A byte landing in the same cycle as a status read wins over the clear.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rx_cnt    <= '0;
            rx_bit    <= '0;
            rx_shift  <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_cnt <= (rx_state == IDLE || rx_sample) ? '0 : rx_cnt + CNT_W'(1);
            if (rx_state == DATA && rx_sample) begin
                rx_shift <= {rx_sync, rx_shift[7:1]};
                rx_bit   <= rx_bit + 3'd1;
            end
            if (rx_done_ok) rx_data <= rx_shift;
            rx_valid  <= rx_done_ok | (rx_valid & ~rd_clear);
            overrun   <= (rx_done_ok & rx_valid) | (overrun & ~rd_clear);
            frame_err <= rx_done_bad | (frame_err & ~rd_clear);
        end
    end

endmodule
